// File: rtl/mac_feeder.sv
// Feeder between a streaming host and a MAC engine: queues signal words in a FIFO,
// starts the MAC on the final word of a batch and returns the captured result to the host.
module mac_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic                  fifo_wr_o,
  output logic [DATA_WIDTH-1:0] signal_o,
  input  logic                  rd_signal_i,
  output logic                  empty_o,
  output logic                  start_o,
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  done_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic                  underflow_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {FILL, WAIT_DONE, RESULT} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] signal_q, signal_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  fifo_wr_q, fifo_wr_d;
  logic                  underflow_q, underflow_d;
  logic                  done_q;
  logic                  full, empty, wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  assign s_ready_o   = (state_q == FILL) && !full;
  assign wr_en       = s_valid_i && s_ready_o;
  assign rd_en       = rd_signal_i && !empty;
  assign empty_o     = empty;
  assign start_o     = (state_q == WAIT_DONE);
  assign m_valid_o   = (state_q == RESULT);
  assign fifo_wr_o   = fifo_wr_q;
  assign signal_o    = signal_q;
  assign m_data_o    = m_data_q;
  assign underflow_o = underflow_q;

  always_comb begin
    state_d     = state_q;
    m_data_d    = m_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    signal_d    = signal_q;
    fifo_wr_d   = wr_en;
    underflow_d = underflow_q || (rd_signal_i && empty);

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      signal_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    case (state_q)
      FILL:      if (wr_en && s_last_i) state_d = WAIT_DONE;
      // A done level held over from a previous batch is not a new completion.
      WAIT_DONE: if (done_i && !done_q) begin
                   state_d  = RESULT;
                   m_data_d = result_i;
                 end
      RESULT:    if (m_ready_i) state_d = FILL;
      default:   state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      signal_q    <= '0;
      m_data_q    <= '0;
      fifo_wr_q   <= 1'b0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      signal_q    <= signal_d;
      m_data_q    <= m_data_d;
      fifo_wr_q   <= fifo_wr_d;
      underflow_q <= underflow_d;
      done_q      <= done_i;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= s_data_i;
  end

endmodule
